// File: rtl/cctrl_link_health_monitor.sv
// Per-channel link supervisor: debounces raw link-up flags, counts qualified losses,
// keeps sticky loss bits, offers counter readback and drives the board status LEDs.
//
// state        | meaning
// -------------+---------------------------------------------------------
// ST_DOWN      | link qualified down, raw flag low
// ST_QUAL_UP   | raw flag high, counting agreeing samples towards UP
// ST_UP        | link qualified up, raw flag high
// ST_QUAL_DOWN | raw flag low, counting agreeing samples towards DOWN
module cctrl_link_health_monitor #(
    parameter int NCHAN           = 8,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int CNT_W           = 16,
    parameter int STRETCH_CYCLES  = 12500000
) (
    input  logic                                          sysClk,
    input  logic                                          sysReset_n,
    input  logic [NCHAN-1:0]                              linkRaw,
    input  logic [NCHAN-1:0]                              chanEnable,
    input  logic                                          clearStrobe,
    input  logic [((NCHAN > 1) ? $clog2(NCHAN) : 1)-1:0]  rdAddr,
    output logic [CNT_W-1:0]                              rdData,
    output logic [NCHAN-1:0]                              linkUp,
    output logic [NCHAN-1:0]                              stickyDown,
    output logic                                          allUp,
    output logic                                          ledOk,
    output logic                                          ledFault
);

    localparam int AW   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int SW   = $clog2(STRETCH_CYCLES + 1);

    localparam logic [DB_W-1:0] DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SW-1:0]   STRETCH_LOAD = SW'(STRETCH_CYCLES);
    localparam logic [AW:0]     NCHAN_A      = (AW + 1)'(NCHAN);

    typedef enum logic [1:0] {
        ST_DOWN,
        ST_QUAL_UP,
        ST_UP,
        ST_QUAL_DOWN
    } link_state_t;

    link_state_t      state    [NCHAN];
    logic [DB_W-1:0]  db_cnt   [NCHAN];
    logic [CNT_W-1:0] loss_cnt [NCHAN];

    logic [NCHAN-1:0] link_up_q;
    logic [NCHAN-1:0] sticky_q;
    logic [NCHAN-1:0] loss_evt;
    logic [CNT_W-1:0] rd_data_q;
    logic             all_up_q;
    logic [SW-1:0]    stretch_cnt;
    logic [SW-1:0]    stretch_next;
    logic             led_fault_q;

    // A loss is the completion of QUAL_DOWN; disabled channels never raise one.
    always_comb begin
        loss_evt = '0;
        for (int i = 0; i < NCHAN; i++) begin
            loss_evt[i] = (state[i] == ST_QUAL_DOWN) && !linkRaw[i] &&
                          (db_cnt[i] == DB_LAST) && chanEnable[i];
        end
    end

    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                state[i]  <= ST_DOWN;
                db_cnt[i] <= '0;
            end
            link_up_q <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                case (state[i])
                    ST_DOWN: begin
                        if (linkRaw[i]) begin
                            state[i]  <= ST_QUAL_UP;
                            db_cnt[i] <= DB_W'(1);
                        end
                    end
                    ST_QUAL_UP: begin
                        if (!linkRaw[i]) begin
                            state[i]  <= ST_DOWN;
                            db_cnt[i] <= '0;
                        end else if (db_cnt[i] == DB_LAST) begin
                            state[i]     <= ST_UP;
                            db_cnt[i]    <= '0;
                            link_up_q[i] <= 1'b1;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + DB_W'(1);
                        end
                    end
                    ST_UP: begin
                        if (!linkRaw[i]) begin
                            state[i]  <= ST_QUAL_DOWN;
                            db_cnt[i] <= DB_W'(1);
                        end
                    end
                    ST_QUAL_DOWN: begin
                        if (linkRaw[i]) begin
                            state[i]  <= ST_UP;
                            db_cnt[i] <= '0;
                        end else if (db_cnt[i] == DB_LAST) begin
                            state[i]     <= ST_DOWN;
                            db_cnt[i]    <= '0;
                            link_up_q[i] <= 1'b0;
                        end else begin
                            db_cnt[i] <= db_cnt[i] + DB_W'(1);
                        end
                    end
                    default: begin
                        state[i]     <= ST_DOWN;
                        db_cnt[i]    <= '0;
                        link_up_q[i] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // A loss coinciding with a clear survives as a count of one.
    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            for (int i = 0; i < NCHAN; i++) begin
                loss_cnt[i] <= '0;
            end
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                if (clearStrobe) begin
                    loss_cnt[i] <= loss_evt[i] ? CNT_W'(1) : '0;
                    sticky_q[i] <= loss_evt[i];
                end else if (loss_evt[i]) begin
                    if (loss_cnt[i] != '1) begin
                        loss_cnt[i] <= loss_cnt[i] + CNT_W'(1);
                    end
                    sticky_q[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            rd_data_q <= '0;
            all_up_q  <= 1'b0;
        end else begin
            rd_data_q <= ({1'b0, rdAddr} < NCHAN_A) ? loss_cnt[rdAddr] : '0;
            all_up_q  <= (chanEnable != '0) && (&(link_up_q | ~chanEnable));
        end
    end

    always_comb begin
        stretch_next = stretch_cnt;
        if (|loss_evt) begin
            stretch_next = STRETCH_LOAD;
        end else if (stretch_cnt != '0) begin
            stretch_next = stretch_cnt - SW'(1);
        end
    end

    always_ff @(posedge sysClk) begin
        if (!sysReset_n) begin
            stretch_cnt <= '0;
            led_fault_q <= 1'b0;
        end else begin
            stretch_cnt <= stretch_next;
            led_fault_q <= (stretch_next != '0);
        end
    end

    assign rdData     = rd_data_q;
    assign linkUp     = link_up_q;
    assign stickyDown = sticky_q;
    assign allUp      = all_up_q;
    assign ledOk      = all_up_q;
    assign ledFault   = led_fault_q;

endmodule

// File: tb/tb_cctrl_link_health_monitor.sv
// Bench for cctrl_link_health_monitor: directed scenarios then randomized traffic,
// every cycle compared against a run-length based behavioural model.
module tb_cctrl_link_health_monitor;

    localparam int N    = 5;
    localparam int DB   = 4;
    localparam int CW   = 2;
    localparam int ST   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          sysClk = 1'b0;
    logic          sysReset_n;
    logic [N-1:0]  linkRaw;
    logic [N-1:0]  chanEnable;
    logic          clearStrobe;
    logic [2:0]    rdAddr;
    logic [CW-1:0] rdData;
    logic [N-1:0]  linkUp;
    logic [N-1:0]  stickyDown;
    logic          allUp;
    logic          ledOk;
    logic          ledFault;

    cctrl_link_health_monitor #(
        .NCHAN(N), .DEBOUNCE_CYCLES(DB), .CNT_W(CW), .STRETCH_CYCLES(ST)
    ) dut (
        .sysClk(sysClk), .sysReset_n(sysReset_n), .linkRaw(linkRaw),
        .chanEnable(chanEnable), .clearStrobe(clearStrobe), .rdAddr(rdAddr),
        .rdData(rdData), .linkUp(linkUp), .stickyDown(stickyDown),
        .allUp(allUp), .ledOk(ledOk), .ledFault(ledFault)
    );

    always #5 sysClk = ~sysClk;

    int vectors     = 0;
    int miscompares = 0;

    // Model: a channel flips its qualified state after DB consecutive disagreeing samples.
    int         run_m [N];
    int         cnt_m [N];
    logic [N-1:0] up_m;
    logic [N-1:0] stk_m;
    int         rd_m;
    logic       allup_m;
    logic       ledf_m;
    int         n_cyc = 0;
    int         last_evt = 0;
    bit         evt_valid = 0;

    logic [N-1:0] target;
    logic [N-1:0] glitch;
    int           hi;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        logic [N-1:0] evt;
        int rd_new;
        n_cyc++;
        if (!sysReset_n) begin
            for (int i = 0; i < N; i++) begin
                run_m[i] = 0;
                cnt_m[i] = 0;
            end
            up_m = '0; stk_m = '0; rd_m = 0; allup_m = 0; ledf_m = 0; evt_valid = 0;
            return;
        end
        rd_new  = (rdAddr < N) ? cnt_m[rdAddr] : 0;
        allup_m = (chanEnable != '0) && ((up_m | ~chanEnable) == {N{1'b1}});
        evt = '0;
        for (int i = 0; i < N; i++) begin
            if (linkRaw[i] != up_m[i]) begin
                run_m[i]++;
                if (run_m[i] == DB) begin
                    up_m[i]  = linkRaw[i];
                    run_m[i] = 0;
                    evt[i]   = !linkRaw[i];
                end
            end else begin
                run_m[i] = 0;
            end
        end
        evt = evt & chanEnable;
        for (int i = 0; i < N; i++) begin
            if (clearStrobe) begin
                cnt_m[i] = evt[i] ? 1 : 0;
                stk_m[i] = evt[i];
            end else if (evt[i]) begin
                if (cnt_m[i] < CMAX) cnt_m[i]++;
                stk_m[i] = 1'b1;
            end
        end
        if (evt != '0) begin
            last_evt  = n_cyc;
            evt_valid = 1;
        end
        ledf_m = evt_valid && ((n_cyc - last_evt) < ST);
        rd_m   = rd_new;
    endtask

    task automatic tick();
        @(posedge sysClk);
        model_update();
        #1;
        check("linkUp",     linkUp,     up_m);
        check("stickyDown", stickyDown, stk_m);
        check("allUp",      allUp,      allup_m);
        check("ledOk",      ledOk,      allup_m);
        check("ledFault",   ledFault,   ledf_m);
        check("rdData",     rdData,     rd_m[CW-1:0]);
    endtask

    initial begin
        sysReset_n = 1'b0; linkRaw = '0; chanEnable = 5'h0F; clearStrobe = 1'b0; rdAddr = '0;
        repeat (3) tick();
        check("rst_linkUp", linkUp, 0);
        check("rst_ledFault", ledFault, 0);

        // rise latency and allUp lag
        sysReset_n = 1'b1;
        repeat (5) tick();
        linkRaw[0] = 1'b1;
        repeat (3) tick();
        check("rise_early", linkUp[0], 0);
        tick();
        check("rise_done", linkUp[0], 1);
        linkRaw = 5'h0F;
        repeat (4) tick();
        check("allup_lag", allUp, 0);
        tick();
        check("allup_set", allUp, 1);

        // glitch rejection, then a real drop on channel 1
        linkRaw[1] = 1'b0;
        repeat (3) tick();
        linkRaw[1] = 1'b1;
        repeat (2) tick();
        check("glitch_up", linkUp[1], 1);
        check("glitch_led", ledFault, 0);
        rdAddr = 3'd1;
        tick();
        check("glitch_cnt", rdData, 0);
        linkRaw[1] = 1'b0;
        repeat (4) tick();
        check("drop_up", linkUp[1], 0);
        check("drop_sticky", stickyDown[1], 1);
        hi = ledFault;
        repeat (12) begin
            tick();
            hi += ledFault;
        end
        check("stretch_len", hi, ST);
        check("drop_allup", allUp, 0);
        check("drop_cnt", rdData, 1);

        // retrigger: channel 3 drops 5 cycles after channel 2
        linkRaw[2] = 1'b0;
        repeat (4) tick();
        hi = ledFault;
        tick();
        hi += ledFault;
        linkRaw[3] = 1'b0;
        repeat (15) begin
            tick();
            hi += ledFault;
        end
        check("retrigger_len", hi, 13);

        // saturation on channel 2 and out-of-range readback
        repeat (4) begin
            linkRaw[2] = 1'b1;
            repeat (4) tick();
            linkRaw[2] = 1'b0;
            repeat (4) tick();
        end
        rdAddr = 3'd2;
        tick();
        check("sat_cnt", rdData, CMAX);
        rdAddr = 3'd7;
        tick();
        check("oor_read", rdData, 0);

        // clear in the same cycle as a loss on channel 3 with prior count 2
        linkRaw[3] = 1'b1;
        repeat (4) tick();
        linkRaw[3] = 1'b0;
        repeat (4) tick();
        linkRaw[3] = 1'b1;
        repeat (4) tick();
        linkRaw[3] = 1'b0;
        repeat (3) tick();
        clearStrobe = 1'b1;
        tick();
        clearStrobe = 1'b0;
        check("clr_sticky", stickyDown, 5'b01000);
        rdAddr = 3'd3;
        tick();
        check("clr_cnt3", rdData, 1);
        rdAddr = 3'd2;
        tick();
        check("clr_cnt2", rdData, 0);

        // enable mask
        clearStrobe = 1'b1;
        tick();
        clearStrobe = 1'b0;
        linkRaw = 5'h0F;
        repeat (6) tick();
        check("mask_allup0", allUp, 1);
        chanEnable = 5'h07;
        linkRaw[3] = 1'b0;
        repeat (4) tick();
        check("mask_up", linkUp[3], 0);
        check("mask_sticky", stickyDown, 0);
        check("mask_led", ledFault, 0);
        rdAddr = 3'd3;
        tick();
        check("mask_cnt", rdData, 0);
        check("mask_allup", allUp, 1);
        chanEnable = '0;
        tick();
        check("none_allup", allUp, 0);
        check("none_ledok", ledOk, 0);

        // randomized traffic
        target = linkRaw;
        chanEnable = 5'h1F;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) target[i] = ~target[i];
            end
            glitch = '0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 11) == 0) glitch[i] = 1'b1;
            end
            linkRaw = target ^ glitch;
            if ($urandom_range(0, 99) == 0) chanEnable = N'($urandom);
            clearStrobe = ($urandom_range(0, 39) == 0);
            rdAddr = 3'($urandom_range(0, 7));
            sysReset_n = ($urandom_range(0, 499) != 0);
            tick();
        end
        sysReset_n = 1'b1;
        clearStrobe = 1'b0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
